vel_cache_reader: RTL and testbench

Sweep engine that reads every particle velocity out of a `VEL_CACHE` instance through the cache's read port and streams the results downstream. It drives the cache's `rd_addr`, captures `vel_out` after the cache's fixed read latency, and emits `(id, velocity)` words over a valid/ready stream. It sits between a velocity cell (cache plus write-side wrapper) and the motion-update / inter-FPGA export path.

---
 rtl/vel_cache_reader.sv | 158 +++++++++++++++
 tb/tb_vel_cache_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vel_cache_reader.sv
// vel_cache_reader: sweeps the VEL_CACHE read port over ids 0..N-1 and
// streams (id, velocity) words through a credit-limited FWFT buffer.
package MD_pkg;
  localparam int PARTICLE_ID_WIDTH  = 6;
  localparam int FLOAT_STRUCT_WIDTH = 32;
endpackage

module vel_cache_reader
  import MD_pkg::*;
#(
  parameter int CACHE_RD_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PARTICLE_ID_WIDTH-1:0]  num_particles,
  output logic                          busy,
  output logic                          done,
  output logic [PARTICLE_ID_WIDTH-1:0]  rd_addr,
  input  logic [FLOAT_STRUCT_WIDTH-1:0] vel_in,
  output logic [FLOAT_STRUCT_WIDTH-1:0] vel_out,
  output logic [PARTICLE_ID_WIDTH-1:0]  vel_id,
  output logic                          vel_valid,
  input  logic                          vel_ready
);
  localparam int L         = CACHE_RD_LATENCY;
  localparam int BUF_DEPTH = L + 2;
  localparam int W         = PARTICLE_ID_WIDTH;
  localparam int FW        = FLOAT_STRUCT_WIDTH;
  localparam int CW        = $clog2(BUF_DEPTH + 1);
  localparam int PW        = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W:0]    n_q, n_d;
  logic [W:0]    cnt_q, cnt_d;
  logic [W-1:0]  rd_addr_q, rd_addr_d;
  logic          iss_q, iss_d;
  logic [L-1:0]  pv_q, pv_d;
  logic [W-1:0]  pid_q [L];
  logic [W-1:0]  pid_d [L];
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [W-1:0]  mid_q [BUF_DEPTH];
  logic [W-1:0]  mid_d [BUF_DEPTH];
  logic [FW-1:0] mvel_q [BUF_DEPTH];
  logic [FW-1:0] mvel_d [BUF_DEPTH];
  logic          push, pop, issue, credit;

  // infl counts words issued but not yet in the buffer (iss_q + pipe);
  // the pop term lets a full buffer keep streaming one word per cycle.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    pid_d     = pid_q;
    mid_d     = mid_q;
    mvel_d    = mvel_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    issue     = 1'b0;
    push      = pv_q[L-1];
    pop       = (fcnt_q != '0) && vel_ready;
    credit    = (int'(infl_q) + int'(fcnt_q) - int'(pop)) < BUF_DEPTH;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d = {1'b0, num_particles};
          if (num_particles == '0) begin
            state_d = DONE;
          end else begin
            issue     = 1'b1;
            rd_addr_d = '0;
            cnt_d     = {{W{1'b0}}, 1'b1};
            state_d   = (num_particles == W'(1)) ? DRAIN : SWEEP;
          end
        end
      end
      SWEEP: begin
        if (credit) begin
          issue     = 1'b1;
          rd_addr_d = cnt_q[W-1:0];
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == n_q - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: state_d = DRAIN;
      DONE:  state_d = IDLE;
    endcase

    iss_d    = issue;
    pv_d     = {pv_q[L-2+1-1:0], iss_q} & {L{1'b1}};
    pid_d[0] = rd_addr_q;
    for (int i = 1; i < L; i++) pid_d[i] = pid_q[i-1];

    if (push) begin
      mid_d[wp_q]  = pid_q[L-1];
      mvel_d[wp_q] = vel_in;
      wp_d = (wp_q == PW'(BUF_DEPTH - 1)) ? '0 : wp_q + 1'b1;
    end
    if (pop) rp_d = (rp_q == PW'(BUF_DEPTH - 1)) ? '0 : rp_q + 1'b1;

    infl_d = infl_q + CW'(issue) - CW'(push);
    fcnt_d = fcnt_q + CW'(push) - CW'(pop);

    if (state_q == DRAIN && infl_d == '0 && fcnt_d == '0)
      state_d = DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      iss_q     <= 1'b0;
      pv_q      <= '0;
      infl_q    <= '0;
      fcnt_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      for (int i = 0; i < L; i++) pid_q[i] <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mid_q[i]  <= '0;
        mvel_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      iss_q     <= iss_d;
      pv_q      <= pv_d;
      infl_q    <= infl_d;
      fcnt_q    <= fcnt_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      pid_q     <= pid_d;
      mid_q     <= mid_d;
      mvel_q    <= mvel_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rd_addr   = rd_addr_q;
  assign vel_valid = (fcnt_q != '0);
  assign vel_out   = vel_valid ? mvel_q[rp_q] : '0;
  assign vel_id    = vel_valid ? mid_q[rp_q] : '0;

  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fcnt_q == CW'(BUF_DEPTH)));
endmodule

// File: tb/tb_vel_cache_reader.sv
// Bench for vel_cache_reader: cache model, stream scoreboard and
// directed sweeps with literal timing expectations.
module tb_vel_cache_reader;
  import MD_pkg::*;
  localparam int W  = PARTICLE_ID_WIDTH;
  localparam int FW = FLOAT_STRUCT_WIDTH;
  localparam int L  = 2;
  localparam int DEPTH = L + 2;

  logic          clk = 1'b0;
  logic          rst, start, vel_ready;
  logic [W-1:0]  num_particles;
  logic          busy, done, vel_valid;
  logic [W-1:0]  rd_addr, vel_id;
  logic [FW-1:0] vel_in, vel_out;

  vel_cache_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .num_particles(num_particles),
    .busy(busy), .done(done), .rd_addr(rd_addr),
    .vel_in(vel_in), .vel_out(vel_out), .vel_id(vel_id),
    .vel_valid(vel_valid), .vel_ready(vel_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] f(input int a);
    logic [31:0] x;
    x = 32'(a) * 32'h9E3779B1 + 32'h0BADF00D;
    return FW'(x);
  endfunction

  // cache: address presented in cycle t is on vel_out in cycle t+L
  logic [W-1:0] ap [L];
  always @(posedge clk) begin
    ap[0] <= rd_addr;
    for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
  end
  assign vel_in = f(int'(ap[L-1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, errs = 0;
  int t0, kc;
  int exp_n, next_id, popped, issued, done_cnt;
  int first_valid, done_cyc, last_hs, busy_cnt;
  bit arm = 0, prev_done, prev_stall;
  logic [W-1:0]  prev_id;
  logic [FW-1:0] prev_dat;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (arm) begin
      kc = cyc - t0 + 1;
      if (prev_done) begin
        chk("post_done_busy", busy, 0);
        chk("post_done_done", done, 0);
      end
      if (prev_stall) begin
        chk("stall_id", vel_id, prev_id);
        chk("stall_data", vel_out, prev_dat);
      end
      if (busy) busy_cnt++;
      if (busy && !done && exp_n > 0) begin
        chk("rd_addr_range", int'(rd_addr) < exp_n, 1);
        if (int'(rd_addr) + 1 > issued) issued = int'(rd_addr) + 1;
        chk("credit", (issued - popped) <= DEPTH, 1);
      end
      if (vel_valid && first_valid < 0) first_valid = kc;
      if (vel_valid && vel_ready) begin
        chk("id_order", vel_id, next_id);
        chk("data", vel_out, f(next_id));
        next_id++;
        popped++;
        last_hs = kc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = kc;
        chk("done_all_ids", next_id, exp_n);
        chk("done_busy", busy, 1);
        if (exp_n > 0) chk("done_after_last", kc, last_hs + 1);
      end
      prev_done  = done;
      prev_stall = vel_valid && !vel_ready;
      prev_id    = vel_id;
      prev_dat   = vel_out;
    end
  end

  task automatic run_sweep(input int n, input int mode,
                           input bit noise, input int abort_at);
    int stall, post;
    bit stalled_once;
    @(posedge clk); #1;
    exp_n = n; next_id = 0; popped = 0; issued = 0; done_cnt = 0;
    first_valid = -1; done_cyc = -1; last_hs = -1; busy_cnt = 0;
    prev_done = 0; prev_stall = 0;
    start = 1'b1;
    num_particles = W'(n);
    vel_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    arm = 1'b1;
    stall = 0; post = 0; stalled_once = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mode == 1 && !stalled_once && next_id == 4) begin
        stall = 10;
        stalled_once = 1;
      end
      if (mode == 2) vel_ready = 1'($urandom_range(0, 1));
      else vel_ready = (stall == 0);
      if (stall > 0) begin
        if (stall == 1) chk("stall_credit_full", issued - popped, DEPTH);
        stall--;
      end
      if (noise && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        num_particles = W'($urandom);
      end else begin
        start = 1'b0;
      end
      if (abort_at > 0 && i + 1 == abort_at) begin
        arm = 1'b0;
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_vel_out", vel_out, 0);
        chk("rst_vel_id", vel_id, 0);
        chk("rst_vel_valid", vel_valid, 0);
        chk("rst_no_done_before", done_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("after_rst_done", done, 0);
          chk("after_rst_valid", vel_valid, 0);
        end
        return;
      end
      if (done_cnt > 0) post++;
      if (post == 4) break;
      @(posedge clk); #1;
    end
    arm = 1'b0;
    start = 1'b0;
    chk("single_done", done_cnt, 1);
    chk("all_ids", next_id, n);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_particles = '0;
    vel_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_vel_out", vel_out, 0);
    chk("reset_vel_id", vel_id, 0);
    chk("reset_vel_valid", vel_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_sweep(4, 0, 0, 0);
    chk("n4_first_valid", first_valid, 4);
    chk("n4_last_hs", last_hs, 7);
    chk("n4_done_cyc", done_cyc, 8);
    chk("n4_busy_cycles", busy_cnt, 8);

    run_sweep(0, 0, 0, 0);
    chk("n0_done_cyc", done_cyc, 1);
    chk("n0_busy_cycles", busy_cnt, 1);
    chk("n0_no_valid", first_valid, -1);

    run_sweep(20, 1, 0, 0);
    run_sweep(20, 0, 1, 0);
    chk("n20_noise_first_valid", first_valid, 4);
    chk("n20_noise_done_cyc", done_cyc, 24);

    run_sweep(10, 0, 0, 6);
    run_sweep(3, 0, 0, 0);
    chk("n3_done_cyc", done_cyc, 7);

    run_sweep((1 << W) - 1, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
